// File: rtl/serial_alu_if.sv
// Start/done handshake and operand/result bundle for serial_alu.
// The requester drives the master side; the ALU implements the slave side.
interface serial_alu_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, overflow, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, overflow, zero
  );
endinterface

// File: rtl/serial_alu.sv
// Bit-serial ALU: one full-adder/gate slice processes a WIDTH-bit operand pair
// LSB first, one bit per clock, behind a start/busy/done handshake.
module serial_alu #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic           clk,
  input  logic           rst,
  serial_alu_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_PASS = 3'b101
  } op_t;

  // Returns {carry_out, sum}.
  function automatic logic [1:0] fulladder_1(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  function automatic logic and_gate(input logic x, input logic y);
    return x & y;
  endfunction

  function automatic logic or_gate(input logic x, input logic y);
    return x | y;
  endfunction

  function automatic logic xor_gate(input logic x, input logic y);
    return x ^ y;
  endfunction

  // Codes 101..111 all collapse onto PASS_A.
  function automatic op_t decode_op(input logic [2:0] code);
    case (code)
      3'b000:  return OP_ADD;
      3'b001:  return OP_SUB;
      3'b010:  return OP_AND;
      3'b011:  return OP_OR;
      3'b100:  return OP_XOR;
      default: return OP_PASS;
    endcase
  endfunction

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] sh_q, sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             b_bit;
  logic             fa_sum;
  logic             fa_co;
  logic             is_arith;
  logic             res_bit;
  logic [WIDTH-1:0] final_res;

  // Single bit slice; SUB is a + ~b with the carry register preloaded to 1.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    res_bit  = a_q[0];
    is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    b_bit    = (op_q == OP_SUB) ? ~b_q[0] : b_q[0];
    {fa_co, fa_sum} = fulladder_1(a_q[0], b_bit, carry_q);
    case (op_q)
      OP_ADD, OP_SUB: res_bit = fa_sum;
      OP_AND:         res_bit = and_gate(a_q[0], b_q[0]);
      OP_OR:          res_bit = or_gate(a_q[0], b_q[0]);
      OP_XOR:         res_bit = xor_gate(a_q[0], b_q[0]);
      default:        res_bit = a_q[0];
    endcase
    final_res = {res_bit, sh_q};
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sh_d     = sh_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      // The DONE cycle accepts a new start like IDLE, giving a WIDTH+1 issue interval.
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          state_d = S_RUN;
          op_d    = decode_op(bus.op);
          a_d     = bus.a;
          b_d     = bus.b;
          cnt_d   = '0;
          carry_d = (decode_op(bus.op) == OP_SUB);
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sh_d    = (WIDTH-1)'({res_bit, sh_q} >> 1);
        carry_d = is_arith ? fa_co : carry_q;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = final_res;
          cout_d   = is_arith & fa_co;
          ovf_d    = is_arith & (carry_q ^ fa_co);
          zero_d   = (final_res == '0);
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu (WIDTH=8): directed vector table, random ops
// against an arithmetic reference model, and handshake/reset sequences.
module tb_serial_alu;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_alu_if #(.WIDTH(W)) bus ();
  serial_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;
  } expect_t;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    expect_t      exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the whole operands.
  function automatic expect_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    expect_t e;
    longint  ua, ub, sa, sb, r, s, smax, smin;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -smax - 1;
    e.cout = 1'b0;
    e.ovf  = 1'b0;
    case (op)
      3'd0: begin
        r = ua + ub;
        s = sa + sb;
        e.cout = (r >= (longint'(1) << W));
        e.ovf  = (s > smax) || (s < smin);
      end
      3'd1: begin
        r = ua - ub;
        s = sa - sb;
        e.cout = (ua >= ub);
        e.ovf  = (s > smax) || (s < smin);
      end
      3'd2:    r = longint'(a & b);
      3'd3:    r = longint'(a | b);
      3'd4:    r = longint'(a ^ b);
      default: r = ua;
    endcase
    e.result = W'(r);
    e.zero   = (e.result == '0);
    return e;
  endfunction

  // Issues one operation, scrambles the operand inputs while running, and checks
  // latency, result hold before done, and the final result and flags.
  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input expect_t exp);
    logic [W-1:0] prev;
    int           lat;
    bit           seen;
    bit           held;
    prev = bus.result;
    lat  = 0;
    seen = 1'b0;
    held = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({name, " busy after accept"}, bus.busy, 1);
    bus.op = 3'($urandom);
    bus.a  = W'($urandom);
    bus.b  = W'($urandom);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) seen = 1'b1;
      else if (bus.result !== prev) held = 1'b0;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
    end
    check({name, " latency"}, lat, W);
    check({name, " result held"}, held, 1);
    check({name, " busy at done"}, bus.busy, 0);
    check({name, " result"}, bus.result, exp.result);
    check({name, " cout"}, bus.cout, exp.cout);
    check({name, " overflow"}, bus.overflow, exp.ovf);
    check({name, " zero"}, bus.zero, exp.zero);
    @(posedge clk);
    #1;
    check({name, " done pulse width"}, bus.done, 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, " busy"}, bus.busy, 0);
    check({name, " done"}, bus.done, 0);
    check({name, " result"}, bus.result, 0);
    check({name, " cout"}, bus.cout, 0);
    check({name, " overflow"}, bus.overflow, 0);
    check({name, " zero"}, bus.zero, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t    vecs[10];
  expect_t e;
  logic [2:0]   rop;
  logic [W-1:0] ra, rb;
  int  last, pulses, idle_wait;
  bit  excl, done_seen;

  initial begin
    vecs[0] = '{"add wrap",     3'b000, 8'hFF, 8'h01, '{8'h00, 1'b1, 1'b0, 1'b1}};
    vecs[1] = '{"sub ovf",      3'b001, 8'h80, 8'h01, '{8'h7F, 1'b1, 1'b1, 1'b0}};
    vecs[2] = '{"and",          3'b010, 8'hA5, 8'hFF, '{8'hA5, 1'b0, 1'b0, 1'b0}};
    vecs[3] = '{"sub borrow",   3'b001, 8'h01, 8'h02, '{8'hFF, 1'b0, 1'b0, 1'b0}};
    vecs[4] = '{"xor",          3'b100, 8'hA5, 8'hFF, '{8'h5A, 1'b0, 1'b0, 1'b0}};
    vecs[5] = '{"or",           3'b011, 8'hA5, 8'hFF, '{8'hFF, 1'b0, 1'b0, 1'b0}};
    vecs[6] = '{"pass 110",     3'b110, 8'hA5, 8'hFF, '{8'hA5, 1'b0, 1'b0, 1'b0}};
    vecs[7] = '{"sub equal",    3'b001, 8'h05, 8'h05, '{8'h00, 1'b1, 1'b0, 1'b1}};
    vecs[8] = '{"add ovf",      3'b000, 8'h80, 8'h80, '{8'h00, 1'b1, 1'b1, 1'b1}};
    vecs[9] = '{"pass 111",     3'b111, 8'h00, 8'hFF, '{8'h00, 1'b0, 1'b0, 1'b1}};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset mid-cycle clears non-zero outputs without a clock edge.
    run_op("add 7f+01", 3'b000, 8'h7F, 8'h01, '{8'h80, 1'b0, 1'b1, 1'b0});
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom);
      rb  = W'($urandom);
      e   = model(rop, ra, rb);
      run_op($sformatf("rand%0d op%0d %02h,%02h", i, rop, ra, rb), rop, ra, rb, e);
    end

    // start held high: one done every WIDTH+1 cycles.
    @(negedge clk);
    bus.op    = 3'b000;
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    bus.start = 1'b1;
    last   = -1;
    pulses = 0;
    excl   = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.busy && bus.done) excl = 1'b0;
      if (bus.done) begin
        pulses++;
        check("hold result", bus.result, 8'h30);
        if (last >= 0) check("hold interval", c - last, W + 1);
        last = c;
      end
    end
    check("hold pulses", pulses, 4);
    check("busy/done exclusive", excl, 1);
    bus.start = 1'b0;
    idle_wait = 0;
    while ((bus.busy || bus.done) && idle_wait < 20) begin
      @(posedge clk);
      #1;
      idle_wait++;
    end
    check("hold drain", bus.busy | bus.done, 0);

    // Reset in the 4th RUN cycle aborts with no done pulse.
    @(negedge clk);
    bus.op    = 3'b000;
    bus.a     = 8'h55;
    bus.b     = 8'h22;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort busy", bus.busy, 0);
    check("abort done", bus.done, 0);
    check("abort result", bus.result, 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) done_seen = 1'b1;
    end
    check("abort no done", done_seen, 0);
    run_op("add after abort", 3'b000, 8'h03, 8'h04, '{8'h07, 1'b0, 1'b0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
